// File: rtl/tag_mem_arbiter.sv
// Shares one tag-memory port between two requesters (round-robin) and routes responses back.
// Define TAG_ARB_CLEAR_EN to compile in the sweep engine that clears every tag word.
module tag_mem_arbiter #(
  parameter int          SIZE     = 8192,
  parameter int          RSP_LAT  = 2,
  parameter logic [31:0] CLR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic        m0_wdata_tag,
  output logic [3:0]  m0_rdata_tag,
  input  logic        m1_req,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic        m1_wdata_tag,
  output logic [3:0]  m1_rdata_tag,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        s_req,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic        s_wdata_tag,
  input  logic [3:0]  s_rdata_tag
);

`ifdef TAG_ARB_CLEAR_EN
  typedef enum logic [1:0] {ID_M0, ID_M1, ID_CLR} owner_e;
`else
  typedef enum logic {ID_M0, ID_M1} owner_e;
`endif

  logic               busy;
  logic               sel_m1;
  logic               accept;
  owner_e             sel_id;
  logic               last_q, last_d;   // 1: m1 was granted most recently
  logic [RSP_LAT-1:0] own_vld_q, own_vld_d;
  owner_e             own_id_q [RSP_LAT];
  owner_e             own_id_d [RSP_LAT];
  logic               rsp_ok;

`ifdef TAG_ARB_CLEAR_EN
  localparam int WORDS = SIZE / 4;
  localparam int IW    = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} clr_state_e;

  clr_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   clr_addr;

  assign busy     = (state_q == ST_SWEEP);
  assign clr_busy = busy;
  assign clr_done = (state_q == ST_DONE);
  assign clr_addr = CLR_BASE + (32'(idx_q) << 2);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: if (clr_start) begin
        state_d = ST_SWEEP;
        idx_d   = '0;
      end
      ST_SWEEP: if (s_gnt) begin
        if (idx_q == IW'(WORDS - 1)) state_d = ST_DONE;
        idx_d = idx_q + IW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
`else
  logic unused_clr;

  assign busy       = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign unused_clr = ^{clr_start, CLR_BASE, SIZE};
`endif

  always_comb begin
    sel_m1      = m1_req && (!m0_req || !last_q);
    s_req       = 1'b0;
    s_addr      = '0;
    s_we        = 1'b0;
    s_be        = '0;
    s_wdata_tag = 1'b0;
    sel_id      = ID_M0;
    if (sel_m1) begin
      s_req       = 1'b1;
      s_addr      = m1_addr;
      s_we        = m1_we;
      s_be        = m1_be;
      s_wdata_tag = m1_wdata_tag;
      sel_id      = ID_M1;
    end else if (m0_req) begin
      s_req       = 1'b1;
      s_addr      = m0_addr;
      s_we        = m0_we;
      s_be        = m0_be;
      s_wdata_tag = m0_wdata_tag;
    end
`ifdef TAG_ARB_CLEAR_EN
    // The sweep owns the port outright; requester selection is overridden.
    if (busy) begin
      s_req       = 1'b1;
      s_addr      = clr_addr;
      s_we        = 1'b1;
      s_be        = 4'b1111;
      s_wdata_tag = 1'b0;
      sel_id      = ID_CLR;
    end
`endif
  end

  assign accept = s_req && s_gnt;
  assign m0_gnt = accept && !busy && (sel_id == ID_M0);
  assign m1_gnt = accept && !busy && (sel_id == ID_M1);

  always_comb begin
    last_d = last_q;
    if (m1_gnt)      last_d = 1'b1;
    else if (m0_gnt) last_d = 1'b0;
    own_vld_d[0] = accept;
    own_id_d[0]  = sel_id;
    for (int k = 1; k < RSP_LAT; k++) begin
      own_vld_d[k] = own_vld_q[k-1];
      own_id_d[k]  = own_id_q[k-1];
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the owner pipeline is reset so responses in flight at reset are dropped, not misrouted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= 1'b1;
      own_vld_q <= '0;
      for (int k = 0; k < RSP_LAT; k++) own_id_q[k] <= ID_M0;
    end else begin
      last_q    <= last_d;
      own_vld_q <= own_vld_d;
      for (int k = 0; k < RSP_LAT; k++) own_id_q[k] <= own_id_d[k];
    end
  end

  assign rsp_ok       = s_rvalid && own_vld_q[RSP_LAT-1];
  assign m0_rvalid    = rsp_ok && (own_id_q[RSP_LAT-1] == ID_M0);
  assign m1_rvalid    = rsp_ok && (own_id_q[RSP_LAT-1] == ID_M1);
  assign m0_rdata_tag = m0_rvalid ? s_rdata_tag : 4'b0;
  assign m1_rdata_tag = m1_rvalid ? s_rdata_tag : 4'b0;

endmodule

// File: doc/tag_mem_arbiter.md
# tag_mem_arbiter

Two-requester arbiter and sweep controller in front of the DIFT tag memory. It shares the single OBI-like tag port between the core LSU tag path (m0) and a secondary requester such as the DMA or debug tag path (m1). It routes each read-valid back to the requester that issued it. Optionally, it contains a clear engine that sweeps the whole tag space to untainted. It sits between the requesters and `tag_mem`.

## Interface
- `SIZE`, 8192: covered data space in bytes; the sweep covers SIZE/4 words.
- `RSP_LAT`, 2: cycles from an accepted downstream request to its `s_rvalid`; legal range 1–4.
- `CLR_BASE`, 32'h0: byte address of the first swept word, 4-byte aligned.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous assertion, active-high.
- `m0_req`, `m1_req`  in  1  requester request.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle.
- `m0_rvalid`, `m1_rvalid`  out  1  response for that requester.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_we`, `m1_we`  in  1  write enable.
- `m0_be`, `m1_be`  in  4  byte enables.
- `m0_wdata_tag`, `m1_wdata_tag`  in  1  write tag.
- `m0_rdata_tag`, `m1_rdata_tag`  out  4  read tags.
- `clr_start`  in  1  one-cycle pulse that launches a sweep.
- `clr_busy`  out  1  sweep in progress.
- `clr_done`  out  1  one-cycle pulse after the last sweep write is accepted.
- `s_req`, `s_gnt`, `s_rvalid`, `s_addr[31:0]`, `s_we`, `s_be[3:0]`, `s_wdata_tag`, `s_rdata_tag[3:0]`  downstream tag-memory port; directions are mirrored from the requester side.

## Operation
**Request path**
- The request path is combinational: the selected source drives `s_*`.
- `mX_gnt = s_gnt && s_req && (selected == mX)`.
- A request is accepted when `s_req && s_gnt`.

**Source selection, highest first**
1. The clear engine, whenever `clr_busy` is high. While it is busy, both requester grants are held at 0.
2. Round-robin between m0 and m1:
   - With exactly one requester active, that requester wins.
   - With both active, the requester not granted last wins.
   - `last` updates only on an accepted requester grant.
   - `last` resets to m1, so m0 wins the first conflict.

**Response routing**
- An owner pipeline of RSP_LAT stages holds {valid, id ∈ {m0, m1, clr}}.
- Stage 0 loads on every accepted request; the pipeline shifts every cycle.
- On `s_rvalid`, the final stage routes the response:
  - `mX_rvalid = s_rvalid && final.valid && final.id == mX`.
  - The owning requester receives `mX_rdata_tag = s_rdata_tag`; the non-owner receives 4'b0.
- Write responses are forwarded the same way as reads.
- Responses whose id is clr are discarded.
- `s_rvalid` while `final.valid` is 0 is ignored (protocol error, no side effect).

**Clear engine**
- States: IDLE → SWEEP → DONE → IDLE.
- IDLE: `clr_start` moves the engine to SWEEP and sets index i = 0. `clr_start` is ignored in SWEEP and DONE.
- SWEEP drives:
  - `s_req` = 1
  - `s_we` = 1
  - `s_be` = 4'b1111
  - `s_wdata_tag` = 0
  - `s_addr` = CLR_BASE + 4*i
- i increments on each accepted request.
- When the write at i = SIZE/4 − 1 is accepted, the engine moves to DONE.
- DONE lasts one cycle: `clr_done` = 1, `clr_busy` = 0, then the engine returns to IDLE.
- The index counter is $clog2(SIZE/4)+1 bits wide and does not wrap.

**Mode switching**
- A requester request already accepted before the sweep starts still gets its response; responses drain through the owner pipeline independently of the FSM.
- On a `clr_start` cycle, requester arbitration still occurs; SWEEP begins the next cycle.

**Reset**
- Reset at any point returns the FSM to IDLE, sets `last` to m1, and sets i to 0.
- All owner stages are invalidated; in-flight responses are dropped.

## Timing
- Reset values:
  - `m0_gnt`, `m1_gnt`, `m0_rvalid`, `m1_rvalid`, `clr_busy`, `clr_done`: 0.
  - `m0_rdata_tag`, `m1_rdata_tag`: 0.
  - `s_req`, `s_we`: 0 when no requester is active.
- Grant is combinational in the request cycle.
- Response: `mX_rvalid` is high in the same cycle as `s_rvalid`, which is RSP_LAT cycles after acceptance. The arbiter adds no latency.
- Throughput: one accepted request per cycle, in both arbitration and sweep.
- Sweep with `s_gnt` constantly 1:
  - `clr_busy` is high for exactly SIZE/4 cycles, starting the cycle after `clr_start`.
  - `clr_done` pulses in the following cycle.
- Stalls: if `s_gnt` is 0 during SWEEP, i holds and the address is re-driven.

## Configuration
- `TAG_ARB_CLEAR_EN` defined: the clear engine is compiled in as described above.
- `TAG_ARB_CLEAR_EN` undefined:
  - The FSM and index counter are removed.
  - `clr_start` is ignored.
  - `clr_busy` and `clr_done` are tied to 0.
  - The owner id space reduces to {m0, m1}.
  - The port list is unchanged.

## Test plan
- m0 read of 0x10 alone, with tag_mem model (RSP_LAT=2) holding 4'b1010 for word 4 → `m0_gnt` in the same cycle; `m0_rvalid` 2 cycles later with `m0_rdata_tag` = 4'b1010; `m1_rvalid` = 0 and `m1_rdata_tag` = 0 throughout.
- m0 and m1 both request for 4 consecutive cycles after reset → grants m0, m1, m0, m1; each rvalid arrives 2 cycles after its own grant and to the correct requester.
- Back-to-back m0 write (addr 0x20, `wdata_tag` = 1) then m1 read of 0x20 → m1 receives 4'b1111 two cycles after its grant.
- With SIZE=64: write taint to all 16 words, then pulse `clr_start` → `clr_busy` for 16 cycles, then `clr_done` pulse; requesters stalled meanwhile; all words then read 4'b0000; no requester rvalid is raised for sweep writes.
- Sweep with `s_gnt` deasserted for 3 cycles at i = 5 → address 0x14 is held; total `clr_busy` duration is 19 cycles.
- Assert `rst` with a read in flight and the sweep at i = 7 → all outputs 0 immediately; the late `s_rvalid` is ignored; the next `clr_start` sweeps from i = 0.
